// File: rtl/vx_core_mem_arb.sv
// Round-robin merge of NUM_REQS core memory request streams into one registered
// memory channel; responses are steered back by the core index kept in the tag LSBs.
module vx_core_mem_arb #(
  parameter int NUM_REQS      = 4,
  parameter int DATA_WIDTH    = 512,
  parameter int ADDR_WIDTH    = 26,
  parameter int TAG_IN_WIDTH  = 8,
  localparam int LOG_NUM_REQS  = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 0,
  localparam int TAG_OUT_WIDTH = TAG_IN_WIDTH + LOG_NUM_REQS
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_REQS-1:0]                  req_valid_in,
  input  logic [NUM_REQS-1:0]                  req_rw_in,
  input  logic [NUM_REQS*(DATA_WIDTH/8)-1:0]   req_byteen_in,
  input  logic [NUM_REQS*ADDR_WIDTH-1:0]       req_addr_in,
  input  logic [NUM_REQS*DATA_WIDTH-1:0]       req_data_in,
  input  logic [NUM_REQS*TAG_IN_WIDTH-1:0]     req_tag_in,
  output logic [NUM_REQS-1:0]                  req_ready_in,
  output logic                                 mem_req_valid,
  output logic                                 mem_req_rw,
  output logic [DATA_WIDTH/8-1:0]              mem_req_byteen,
  output logic [ADDR_WIDTH-1:0]                mem_req_addr,
  output logic [DATA_WIDTH-1:0]                mem_req_data,
  output logic [TAG_OUT_WIDTH-1:0]             mem_req_tag,
  input  logic                                 mem_req_ready,
  input  logic                                 mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]                mem_rsp_data,
  input  logic [TAG_OUT_WIDTH-1:0]             mem_rsp_tag,
  output logic                                 mem_rsp_ready,
  output logic [NUM_REQS-1:0]                  rsp_valid_out,
  output logic [NUM_REQS*DATA_WIDTH-1:0]       rsp_data_out,
  output logic [NUM_REQS*TAG_IN_WIDTH-1:0]     rsp_tag_out,
  input  logic [NUM_REQS-1:0]                  rsp_ready_out
);
  localparam int IW = (LOG_NUM_REQS > 0) ? LOG_NUM_REQS : 1;
  localparam int BW = DATA_WIDTH / 8;

  logic                     out_valid;
  logic [IW-1:0]            rr_ptr, grant, next_ptr;
  logic                     any_valid, stage_en, in_fire;
  logic [TAG_OUT_WIDTH-1:0] tag_cat;

  // Walk offsets high to low so the lowest offset from rr_ptr wins.
  always_comb begin
    grant     = rr_ptr;
    any_valid = 1'b0;
    for (int k = NUM_REQS - 1; k >= 0; k--) begin
      int j;
      j = int'(rr_ptr) + k;
      if (j >= NUM_REQS) j = j - NUM_REQS;
      if (req_valid_in[j]) begin
        grant     = IW'(j);
        any_valid = 1'b1;
      end
    end
  end

  always_comb begin
    int n;
    n = int'(grant) + 1;
    if (n >= NUM_REQS) n = 0;
    next_ptr = IW'(n);
  end

  assign stage_en      = !out_valid || mem_req_ready;
  assign in_fire       = stage_en && any_valid && !reset;
  assign mem_req_valid = out_valid && !reset;

  for (genvar i = 0; i < NUM_REQS; i++) begin : g_rdy
    assign req_ready_in[i] = in_fire && req_valid_in[i] && (int'(grant) == i);
  end

  if (LOG_NUM_REQS > 0) begin : g_tag_idx
    assign tag_cat = {req_tag_in[grant*TAG_IN_WIDTH +: TAG_IN_WIDTH], grant};
  end else begin : g_tag_pass
    assign tag_cat = req_tag_in[grant*TAG_IN_WIDTH +: TAG_IN_WIDTH];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      rr_ptr    <= '0;
    end else if (in_fire) begin
      out_valid <= 1'b1;
      rr_ptr    <= next_ptr;
    end else if (mem_req_ready) begin
      out_valid <= 1'b0;
    end
    // Payload is don't-care while out_valid is low, so it carries no reset.
    if (in_fire) begin
      mem_req_rw     <= req_rw_in[grant];
      mem_req_byteen <= req_byteen_in[grant*BW +: BW];
      mem_req_addr   <= req_addr_in[grant*ADDR_WIDTH +: ADDR_WIDTH];
      mem_req_data   <= req_data_in[grant*DATA_WIDTH +: DATA_WIDTH];
      mem_req_tag    <= tag_cat;
    end
  end

  logic [IW-1:0]           rsp_idx;
  logic [TAG_IN_WIDTH-1:0] rsp_tag;
  logic                    idx_ok;

  if (LOG_NUM_REQS > 0) begin : g_rsp_idx
    assign rsp_idx = mem_rsp_tag[LOG_NUM_REQS-1:0];
    assign rsp_tag = mem_rsp_tag[TAG_OUT_WIDTH-1:LOG_NUM_REQS];
  end else begin : g_rsp_pass
    assign rsp_idx = '0;
    assign rsp_tag = mem_rsp_tag;
  end

  // Indices past NUM_REQS only exist for non-power-of-2 builds; never route them.
  assign idx_ok        = int'(rsp_idx) < NUM_REQS;
  assign mem_rsp_ready = idx_ok && rsp_ready_out[rsp_idx];
  assign rsp_data_out  = {NUM_REQS{mem_rsp_data}};
  assign rsp_tag_out   = {NUM_REQS{rsp_tag}};

  for (genvar i = 0; i < NUM_REQS; i++) begin : g_rsp
    assign rsp_valid_out[i] = mem_rsp_valid && (int'(rsp_idx) == i);
  end

  a_rsp_idx: assert property (@(posedge clk) disable iff (reset) mem_rsp_valid |-> idx_ok);

endmodule

// File: doc/vx_core_mem_arb.md
Name: vx_core_mem_arb

Overview:
- Downstream neighbour of the per-core memory port.
- Merges the memory request streams of NUM_REQS cores into a single memory request channel using round-robin arbitration behind a one-entry output register.
- Appends the winning core index to the request tag.
- Routes memory responses back to the originating core by decoding the appended tag bits.
- Sits between the cores of a cluster and the shared L2/memory port.

Parameters:
- NUM_REQS, 4, number of core-side request/response ports (≥1).
- DATA_WIDTH, 512, memory line data width in bits.
- ADDR_WIDTH, 26, line address width in bits.
- TAG_IN_WIDTH, 8, core-side tag width.
- LOG_NUM_REQS, (NUM_REQS>1 ? clog2(NUM_REQS) : 0), index bits; derived, not overridden.
- TAG_OUT_WIDTH, TAG_IN_WIDTH+LOG_NUM_REQS, memory-side tag width; derived.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_valid_in  in  NUM_REQS  per-core request valid.
- req_rw_in  in  NUM_REQS  per-core write enable.
- req_byteen_in  in  NUM_REQS*DATA_WIDTH/8  per-core byte enables, flattened, core i at slice i.
- req_addr_in  in  NUM_REQS*ADDR_WIDTH  per-core address.
- req_data_in  in  NUM_REQS*DATA_WIDTH  per-core write data.
- req_tag_in  in  NUM_REQS*TAG_IN_WIDTH  per-core tag.
- req_ready_in  out  NUM_REQS  per-core accept.
- mem_req_valid  out  1  merged request valid.
- mem_req_rw  out  1  merged write enable.
- mem_req_byteen  out  DATA_WIDTH/8  merged byte enables.
- mem_req_addr  out  ADDR_WIDTH  merged address.
- mem_req_data  out  DATA_WIDTH  merged data.
- mem_req_tag  out  TAG_OUT_WIDTH  {core tag, core index}, index in LSBs.
- mem_req_ready  in  1  memory accepts request.
- mem_rsp_valid  in  1  memory response valid.
- mem_rsp_data  in  DATA_WIDTH  response data.
- mem_rsp_tag  in  TAG_OUT_WIDTH  response tag.
- mem_rsp_ready  out  1  response accepted.
- rsp_valid_out  out  NUM_REQS  per-core response valid.
- rsp_data_out  out  NUM_REQS*DATA_WIDTH  response data, broadcast to all slices.
- rsp_tag_out  out  NUM_REQS*TAG_IN_WIDTH  response tag with index stripped, broadcast.
- rsp_ready_out  in  NUM_REQS  per-core response accept.

Behaviour:
- Handshake: valid/ready everywhere. A transfer fires when valid && ready in the same cycle. A valid request must hold stable until it fires; the block never drops or duplicates one.
- Request stage: one output register (out_valid + payload). stage_en = !out_valid || mem_req_ready.
- Arbitration: round-robin over asserted req_valid_in, starting search at pointer rr_ptr.
  - grant = first i from rr_ptr upward, modulo NUM_REQS, with req_valid_in[i]=1.
  - req_ready_in[i] = stage_en && grant==i && req_valid_in[i]. At most one bit is high.
- On an input fire:
  - Register captures the payload; mem_req_tag = {req_tag_in[grant], grant[LOG_NUM_REQS-1:0]}.
  - out_valid ← 1.
  - rr_ptr ← (grant+1) mod NUM_REQS.
- On mem_req fire with no new input fire: out_valid ← 0.
- Simultaneous mem_req fire and input fire: register reloads. Back-to-back throughput is 1 request/cycle.
- Latency: input fire in cycle N → mem_req_valid high in cycle N+1.
- Backpressure: while mem_req_ready=0 and out_valid=1, all req_ready_in=0. rr_ptr and the register hold.
- No valid inputs: rr_ptr unchanged; out_valid drains normally.
- Response path, combinational, zero latency:
  - idx = mem_rsp_tag[LOG_NUM_REQS-1:0].
  - rsp_valid_out[i] = mem_rsp_valid && idx==i.
  - rsp_tag_out slices = mem_rsp_tag[TAG_OUT_WIDTH-1:LOG_NUM_REQS].
  - mem_rsp_ready = rsp_ready_out[idx].
  - idx ≥ NUM_REQS (non-power-of-2 NUM_REQS): no rsp_valid_out asserted and mem_rsp_ready=0. A simulation assertion flags it.
- NUM_REQS=1: pure pass-through with the one-entry register. Tags are unmodified (LOG_NUM_REQS=0). mem_rsp_ready = rsp_ready_out[0].
- Reset (synchronous, any cycle including mid-stall):
  - Registered state: out_valid=0, rr_ptr=0.
  - Outputs: mem_req_valid=0 and req_ready_in=0 during reset; any held request is discarded.
  - Payload registers need no reset.
- Response outputs are combinational from inputs and are not forced by reset.

Test Plan:
- Single requester: core 2 issues addr=0x100, tag=0x5A, mem_req_ready=1 → next cycle mem_req_valid=1, addr=0x100, mem_req_tag=0x5A<<2|2=0x16A; req_ready_in[2] high exactly one cycle.
- All four valid continuously, mem_req_ready=1 from reset → grants in order 0,1,2,3,0, one per cycle; mem_req_valid high every cycle from cycle 1.
- Backpressure: out_valid=1, mem_req_ready=0 for 5 cycles with cores 1 and 3 valid → all req_ready_in=0 and mem_req_* stable; on release, core 1 is granted (rr_ptr=1), then core 3.
- Response routing: mem_rsp_tag=0x16A, rsp_ready_out=4'b0100 → rsp_valid_out=4'b0100, rsp_tag_out=0x5A, mem_rsp_ready=1. With rsp_ready_out=4'b1011 → mem_rsp_ready=0.
- Reset mid-stall: out_valid=1, mem_req_ready=0, assert reset 1 cycle → mem_req_valid=0 next cycle; the first subsequent grant goes to core 0 when all cores are valid.
- NUM_REQS=1 build: tag 0x33 in → mem_req_tag=0x33 after 1 cycle; response tag 0x33 → rsp_valid_out[0]=1, rsp_tag_out=0x33.
